// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the start/busy handshake to the UART serializer.
// The master side is the arbiter and the slave side is the environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [GW-1:0]        grant_id;
  logic                 grant_active;
  logic                 err_timeout;
  logic                 pkt_abort;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout, pkt_abort
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout, pkt_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one 8N1 UART transmitter between
// NUM_REQ byte streams, with recovery from stalled requesters and transmitters.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_PKT_LEN  = 16,
  parameter int BUSY_TIMEOUT = 16,
  parameter int IDLE_TIMEOUT = 50000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    ISSUE     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, grant_id, pick, next_ptr;
  logic          grant_active, last_q;
  logic [7:0]    tx_data_q, byte_cnt, g_data;
  logic [BW-1:0] busy_cnt;
  logic [IW-1:0] idle_cnt;
  logic          any_valid, g_valid, g_last;
  logic          accept, release_now, busy_to, idle_to;

  function automatic logic [BW-1:0] sat_busy(input logic [BW-1:0] c);
    return (c == BW'(BUSY_TIMEOUT)) ? c : c + 1'b1;
  endfunction

  function automatic logic [IW-1:0] sat_idle(input logic [IW-1:0] c);
    return (c == IW'(IDLE_TIMEOUT)) ? c : c + 1'b1;
  endfunction

  // Scan downward so the last hit is the nearest index at or after rr_ptr.
  always_comb begin
    any_valid = 1'b0;
    pick      = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = GW'(idx);
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    release_now = 1'b0;
    busy_to     = 1'b0;
    idle_to     = 1'b0;
    case (state)
      ARB: if (any_valid) state_nxt = ISSUE;
      ISSUE: begin
        if (g_valid) begin
          if (!bus.tx_busy) begin
            accept    = 1'b1;
            state_nxt = START;
          end
        end else if (idle_cnt >= IW'(IDLE_TIMEOUT - 1)) begin
          idle_to     = 1'b1;
          release_now = 1'b1;
          state_nxt   = ARB;
        end
      end
      START: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (busy_cnt >= BW'(BUSY_TIMEOUT - 1)) begin
          busy_to     = 1'b1;
          release_now = 1'b1;
          state_nxt   = ARB;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q || byte_cnt == 8'(MAX_PKT_LEN)) begin
            release_now = 1'b1;
            state_nxt   = ARB;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      tx_data_q    <= 8'h00;
      last_q       <= 1'b0;
      byte_cnt     <= 8'h00;
      busy_cnt     <= '0;
      idle_cnt     <= '0;
    end else begin
      case (state)
        ARB: begin
          if (any_valid) begin
            grant_id     <= pick;
            grant_active <= 1'b1;
            byte_cnt     <= 8'h00;
            idle_cnt     <= '0;
          end
        end
        ISSUE: begin
          if (accept) begin
            tx_data_q <= g_data;
            last_q    <= g_last;
            byte_cnt  <= byte_cnt + 8'd1;
          end else if (!g_valid) begin
            idle_cnt <= sat_idle(idle_cnt);
          end
        end
        START:     busy_cnt <= '0;
        WAIT_BUSY: busy_cnt <= sat_busy(busy_cnt);
        WAIT_DONE: if (!bus.tx_busy) idle_cnt <= '0;
        default: ;
      endcase
      if (release_now) begin
        rr_ptr       <= next_ptr;
        grant_active <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (grant_id == GW'(i));
    end
  end

  assign bus.tx_start     = (state == START);
  assign bus.tx_data      = tx_data_q;
  assign bus.grant_id     = grant_id;
  assign bus.grant_active = grant_active;
  assign bus.err_timeout  = busy_to;
  assign bus.pkt_abort    = idle_to;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level round-robin model feeds
// an expected-byte queue that a monitor drains on every tx_start.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXP = 4;
  localparam int BT   = 16;
  localparam int IT   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N), .MAX_PKT_LEN(MAXP), .BUSY_TIMEOUT(BT), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int         tests = 0;
  int         fails = 0;
  logic [8:0] rq [N][$];   // {last, data} per requester
  logic [9:0] exp_q [$];   // {grant id, data}
  int         got_id [$];
  int         model_rr = 0;
  logic [N-1:0] acc = '0;
  logic       busy_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Packet-level reference: serve non-empty requesters round-robin, each grant
  // taking bytes until last, MAX_PKT_LEN, or the requester runs dry.
  task automatic model_push();
    logic [8:0] cq [N][$];
    logic [8:0] e;
    int g, n;
    bit found;
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    forever begin
      found = 0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && cq[(model_rr + k) % N].size() > 0) begin
          found = 1;
          g = (model_rr + k) % N;
        end
      end
      if (!found) break;
      n = 0;
      do begin
        e = cq[g].pop_front();
        exp_q.push_back({g[1:0], e[7:0]});
        n++;
      end while (!e[8] && n < MAXP && cq[g].size() > 0);
      model_rr = (g + 1) % N;
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) rq[r].push_back({(b == len - 1), 8'($urandom)});
  endtask

  function automatic bit queues_busy();
    bit b = (exp_q.size() > 0);
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int bound);
    int c = 0;
    bit pend;
    do begin
      cyc();
      c++;
      pend = bus.grant_active || queues_busy();
    end while (pend && c < bound);
    if (pend) begin
      tests++;
      fails++;
      $display("FAIL drain: traffic still pending after %0d cycles", bound);
    end
  endtask

  task automatic wait_start(input int bound);
    int c = 0;
    while (!bus.tx_start && c < bound) begin cyc(); c++; end
    if (!bus.tx_start) begin
      tests++;
      fails++;
      $display("FAIL wait_tx_start: no tx_start within %0d cycles", bound);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    got_id.delete();
    model_rr = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_grant_active"}, 32'(bus.grant_active), 0);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
    chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 0);
    chk({tag, "_pkt_abort"}, 32'(bus.pkt_abort), 0);
    chk({tag, "_state"}, 32'(dut.state), 0);
    chk({tag, "_rr_ptr"}, 32'(dut.rr_ptr), 0);
  endtask

  // Requester drivers: pop on the previous cycle's acceptance, present heads.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = rq[i][0][7:0];
          bus.req_last[i]        = rq[i][0][8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
      #2;
      acc = rst ? '0 : bus.req_ready;
      if (acc != '0) begin
        chk("req_ready_grantee", 32'(acc), 32'(1) << bus.grant_id);
        chk("req_ready_active", 32'(bus.grant_active), 1);
      end
    end
  end

  // Transmitter model: busy rises 0..2 cycles after tx_start, lasts 3..12 cycles.
  initial begin
    int d, len;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start && busy_en) begin
        d   = $urandom_range(0, 2);
        len = $urandom_range(3, 12);
        repeat (d) @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (len) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [9:0] e;
    forever begin
      cyc();
      if (!rst && bus.tx_start) begin
        got_id.push_back(int'(bus.grant_id));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_start_unexpected: data 0x%0h from grant %0d, none expected",
                   bus.tx_data, bus.grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
          chk("tx_grant_id", 32'(bus.grant_id), 32'(e[9:8]));
        end
      end
    end
  end

  initial begin
    int c;
    int ford [6] = '{0, 1, 2, 3, 0, 1};
    int xord [7] = '{0, 0, 0, 0, 1, 0, 0};

    rst = 1'b1;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    // Single 3-byte packet from requester 2.
    rq[2].push_back({1'b0, 8'h41});
    rq[2].push_back({1'b0, 8'h42});
    rq[2].push_back({1'b1, 8'h43});
    model_push();
    drain(500);
    chk("single_count", 32'(got_id.size()), 3);
    for (int k = 0; k < 3; k++) chk("single_grant", 32'(got_id[k]), 2);
    chk("single_release", 32'(bus.grant_active), 0);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 3);

    // Fairness with 1-byte packets.
    do_reset();
    for (int r = 0; r < N; r++) add_pkt(r, 1);
    add_pkt(0, 1);
    add_pkt(1, 1);
    model_push();
    drain(1000);
    chk("fair_count", 32'(got_id.size()), 6);
    for (int k = 0; k < 6; k++) chk("fair_order", 32'(got_id[k]), 32'(ford[k]));

    // Forced release at MAX_PKT_LEN.
    do_reset();
    add_pkt(0, 6);
    add_pkt(1, 1);
    model_push();
    drain(1000);
    chk("forced_count", 32'(got_id.size()), 7);
    for (int k = 0; k < 7; k++) chk("forced_order", 32'(got_id[k]), 32'(xord[k]));

    // Randomized traffic rounds.
    for (int round = 0; round < 4; round++) begin
      for (int r = 0; r < N; r++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(r, $urandom_range(1, 6));
      end
      model_push();
      drain(5000);
    end

    // Busy timeout with a dead transmitter.
    do_reset();
    busy_en = 1'b0;
    add_pkt(0, 1);
    add_pkt(1, 1);
    model_push();
    for (int k = 0; k < 2; k++) begin
      wait_start(50);
      chk("timeout_grant", 32'(bus.grant_id), 32'(k));
      c = 0;
      do begin cyc(); c++; end while (!bus.err_timeout && c < 100);
      chk("timeout_cycles", 32'(c), BT);
      cyc();
      chk("timeout_release", 32'(bus.grant_active), 0);
      chk("timeout_pulse", 32'(bus.err_timeout), 0);
    end
    drain(200);
    busy_en = 1'b1;

    // Idle abort after a non-last byte.
    do_reset();
    rq[1].push_back({1'b0, 8'h5A});
    model_push();
    wait_start(50);
    c = 0;
    while (!bus.tx_busy && c < 50) begin cyc(); c++; end
    c = 0;
    while (bus.tx_busy && c < 50) begin cyc(); c++; end
    c = 0;
    do begin cyc(); c++; end while (!bus.pkt_abort && c < 100);
    chk("abort_cycles", 32'(c), IT);
    cyc();
    chk("abort_release", 32'(bus.grant_active), 0);
    chk("abort_pulse", 32'(bus.pkt_abort), 0);

    // Reset while the first byte is in flight.
    do_reset();
    add_pkt(0, 3);
    model_push();
    wait_start(50);
    c = 0;
    while (!bus.tx_busy && c < 50) begin cyc(); c++; end
    cyc();
    cyc();
    chk("midrst_in_wait_done", 32'(dut.state), 4);
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    got_id.delete();
    model_rr = 0;
    cyc();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    for (int r = 0; r < N; r++) add_pkt(r, 1);
    model_push();
    c = 0;
    while (!bus.grant_active && c < 50) begin cyc(); c++; end
    chk("midrst_first_grant", 32'(bus.grant_id), 0);
    drain(1000);
    chk("midrst_count", 32'(got_id.size()), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
